// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: issues sequential fetch addresses, redirects on
// taken branches with a fixed flush window, and parks in HALT on request.
module pc_sequencer #(
    parameter int unsigned      PC_W         = 32,
    parameter int unsigned      OFF_W        = 22,
    parameter logic [PC_W-1:0]  RESET_PC     = '0,
    parameter int unsigned      FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [PC_W-1:0]  fetch_pc,
    input  logic             br_valid,
    input  logic             br_take,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_off,
    input  logic             halt_req,
    output logic             flush,
    output logic             redirect,
    output logic             halted
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic [PC_W-1:0]  br_base;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  target;

    // Branch PC low bits are masked rather than sliced off so the whole port is consumed.
    assign br_base = br_pc & ~PC_W'(3);
    assign off_ext = {{(PC_W - OFF_W){br_off[OFF_W-1]}}, br_off};
    assign target  = br_base + PC_W'(4) + (off_ext << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            flush_cnt   <= '0;
            fetch_pc    <= RESET_PC;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    // A taken branch wins over both halt and the sequential increment.
                    if (br_valid && br_take) begin
                        state       <= FLUSH;
                        fetch_pc    <= target;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b1;
                        redirect    <= 1'b1;
                        flush_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        if (fetch_valid && fetch_ready)
                            fetch_pc <= fetch_pc + PC_W'(4);
                        if (halt_req) begin
                            state       <= HALT;
                            fetch_valid <= 1'b0;
                            halted      <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state       <= RUN;
                        flush       <= 1'b0;
                        fetch_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                HALT: begin
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected outputs per
// driven cycle; an independent monitor pops and compares after each rising edge.
module tb_pc_sequencer;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned OFF_W = 22;
    localparam int unsigned FC    = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fetch_valid;
    logic             fetch_ready = 1'b0;
    logic [PC_W-1:0]  fetch_pc;
    logic             br_valid = 1'b0;
    logic             br_take = 1'b0;
    logic [PC_W-1:0]  br_pc = '0;
    logic [OFF_W-1:0] br_off = '0;
    logic             halt_req = 1'b0;
    logic             flush;
    logic             redirect;
    logic             halted;

    pc_sequencer #(
        .PC_W(PC_W),
        .OFF_W(OFF_W),
        .RESET_PC(RPC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc),
        .br_valid(br_valid),
        .br_take(br_take),
        .br_pc(br_pc),
        .br_off(br_off),
        .halt_req(halt_req),
        .flush(flush),
        .redirect(redirect),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        flush;
        logic        redirect;
        logic        halted;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: abstract phase flags and a remaining-flush-cycle count.
    logic [31:0] m_pc;
    bit          m_valid, m_flush, m_redir, m_halted, m_boot;
    int          flush_left;

    function automatic exp_t model_out();
        exp_t e;
        e.valid    = m_valid;
        e.pc       = m_pc;
        e.flush    = m_flush;
        e.redirect = m_redir;
        e.halted   = m_halted;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_valid = 0; m_flush = 0; m_redir = 0; m_halted = 0;
        m_boot = 1; flush_left = 0;
    endtask

    task automatic model_next(input bit rdy, bv, bt, input logic [31:0] bp,
                              input logic [21:0] bo, input bit hr);
        longint          base;
        longint          off;
        logic signed [21:0] so;
        m_redir = 0;
        if (m_boot) begin
            m_boot  = 0;
            m_valid = 1;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (flush_left > 0) begin
            flush_left--;
            if (flush_left == 0) begin
                m_flush = 0;
                m_valid = 1;
            end
        end else if (bv && bt) begin
            base = longint'(bp & 32'hFFFF_FFFC);
            so   = bo;
            off  = so;
            m_pc = 32'(base + 4 + off * 4);
            m_valid = 0; m_flush = 1; m_redir = 1;
            flush_left = FC;
        end else begin
            if (rdy) m_pc = m_pc + 32'd4;
            if (hr) begin
                m_valid  = 0;
                m_halted = 1;
            end
        end
    endtask

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a.valid = fetch_valid; a.pc = fetch_pc; a.flush = flush;
        a.redirect = redirect; a.halted = halted;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got v=%b pc=%h fl=%b rd=%b h=%b want v=%b pc=%h fl=%b rd=%b h=%b",
                     name, $time, a.valid, a.pc, a.flush, a.redirect, a.halted,
                     e.valid, e.pc, e.flush, e.redirect, e.halted);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the model's expectation.
    task automatic step(input bit rst, rdy, bv, bt, input logic [31:0] bp,
                        input logic [21:0] bo, input bit hr);
        bit was_running;
        @(negedge clk);
        was_running = rst_n;
        rst_n = rst; fetch_ready = rdy; br_valid = bv; br_take = bt;
        br_pc = bp; br_off = bo; halt_req = hr;
        if (!rst) begin
            model_reset();
            if (was_running) begin
                #1;
                check("async_reset", model_out());
            end
        end else begin
            model_next(rdy, bv, bt, bp, bo, hr);
        end
        q.push_back(model_out());
    endtask

    task automatic idle(input int n, input bit rdy, input bit hr);
        for (int i = 0; i < n; i++) step(1, rdy, 0, 0, '0, '0, hr);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle", e);
            end
        end
    end

    initial begin : stim
        model_reset();
        // T1 reset and first fetches
        step(0, 0, 0, 0, '0, '0, 0);
        step(0, 1, 0, 0, '0, '0, 0);
        idle(3, 1, 0);
        // T2 backpressure at 0x8
        idle(3, 0, 0);
        idle(1, 1, 0);
        // T3 taken backward branch to 0xFC
        step(1, 1, 1, 1, 32'h100, 22'h3FFFFE, 0);
        idle(4, 1, 0);
        // T4 not-taken branch
        step(1, 1, 1, 0, 32'h40, 22'd10, 0);
        idle(2, 1, 0);
        // T5 wrap-around target with same-cycle halt, squashed branches in flush
        step(1, 1, 1, 1, 32'hFFFF_FFFC, 22'd1, 1);
        step(1, 1, 1, 1, 32'h200, 22'd8, 1);
        step(1, 0, 1, 1, 32'h300, 22'd8, 1);
        idle(4, 1, 1);
        // T6 reset during the first flush cycle
        step(0, 1, 0, 0, '0, '0, 0);
        idle(4, 1, 0);
        step(1, 1, 1, 1, 32'h80, 22'd3, 0);
        step(0, 1, 0, 0, '0, '0, 0);
        idle(4, 1, 0);
        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom,
                 22'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
